// File: rtl/gry_bin_seq.sv
// Serial Gray-to-binary decoder, MSB first, one bit per clock, valid/ready on both sides.
// Optional adjacency check on accepted words is enabled by defining GRY_BIN_STEP_EN.
module gry_bin_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] gray,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] binary,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         step_err
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE, out_valid only in DONE; neither depends
  // combinationally on in_valid or out_ready.
  localparam int            IW      = $clog2(N);
  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  g_q, g_d;
  logic [N-1:0]  res_q, res_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  res_upper;
  logic          accept;

  assign accept    = (state_q == IDLE) && in_valid;
  // res_upper[i] is res[i+1], with a zero above the MSB
  assign res_upper = {1'b0, res_q[N-1:1]};

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    res_d   = res_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          g_d     = gray;
          res_d   = '0;
          idx_d   = IDX_TOP;
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d[idx_q] = g_q[idx_q] ^ res_upper[idx_q];
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      res_q   <= '0;
      idx_q   <= IDX_TOP;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign binary    = res_q;

`ifdef GRY_BIN_STEP_EN
  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] prev_q, prev_d;
  logic [N-1:0] diff;
  logic         prev_vld_q, prev_vld_d;
  logic         step_err_q, step_err_d;

  // More than one set bit in diff <=> clearing its lowest set bit leaves something
  assign diff = gray ^ prev_q;

  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    step_err_d = step_err_q;
    if (accept) begin
      step_err_d = prev_vld_q && ((diff & (diff - ONE_N)) != '0);
      prev_d     = gray;
      prev_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      step_err_q <= step_err_d;
    end
  end

  assign step_err = step_err_q;
`else
  assign step_err = 1'b0;
`endif

endmodule
